uart_loanio_xcvr: RTL and testbench
===================================

// Module: uart_loanio_xcvr
// PURPOSE
//  FPGA-fabric UART transceiver driving the HPS UART pins over the HPS loan-IO bus of the uart system.
//  TX serialises bytes onto loan IO 50; RX deserialises loan IO 49.
//  Sits between fabric logic (valid/ready byte streams) and hps_0_h2f_loan_io_{in,out,oe}.
//  Format: 8N1, LSB first, idle-high line.
// PARAMETERS
//  CLK_HZ      50000000  clk_clk frequency in Hz
//  BAUD        115200    line bit rate
//  OVERSAMPLE  16        sample ticks per bit; must be even and >= 8
//  RX_PIN      49        loan-IO index used as serial input
//  TX_PIN      50        loan-IO index used as serial output
// PORTS
//  clk_clk        in   1   single clock; all logic is rising-edge
//  reset_reset    in   1   asynchronous reset, active-high
//  tx_data        in   8   byte to transmit
//  tx_valid       in   1   tx_data valid
//  tx_ready       out  1   transmitter can accept a byte
//  rx_data        out  8   received byte, held while rx_valid
//  rx_valid       out  1   rx_data valid
//  rx_ready       in   1   consumer accepts rx_data
//  rx_frame_err   out  1   1-cycle pulse: stop bit sampled low
//  rx_overrun     out  1   1-cycle pulse: byte completed while rx_valid still high
//  rx_parity_err  out  1   1-cycle pulse: parity mismatch (0 when UART_PARITY_EN is undefined)
//  loan_io_in     in   67  from hps_0_h2f_loan_io_in
//  loan_io_out    out  67  to hps_0_h2f_loan_io_out
//  loan_io_oe     out  67  to hps_0_h2f_loan_io_oe
// BEHAVIOUR
//  - Reset values: tx_ready=1, rx_valid=0, rx_data=0, all error pulses 0, loan_io_out[TX_PIN]=1,
//    loan_io_oe[TX_PIN]=1; all other loan_io_out/oe bits are constantly 0.
//  - Tick generator: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), minimum 1. Free-running counter 0..DIV-1;
//    tick is asserted for 1 cycle at wrap. The counter is shared by TX and RX.
//  - TX FSM: IDLE->START->DATA(8 bits)->[PARITY]->STOP->IDLE. Each bit lasts OVERSAMPLE ticks.
//    Handshake: tx_ready=1 only in IDLE; a byte is accepted when tx_valid&&tx_ready, and it is captured
//    into a shift register the same cycle. tx_ready drops the next cycle and returns in the cycle after
//    the stop bit ends. The START bit starts at the next tick after acceptance.
//  - RX: loan_io_in[RX_PIN] passes through a 2-FF synchroniser, reset to 1.
//    FSM IDLE->START->DATA->[PARITY]->STOP->IDLE; RESYNC is entered after a framing error.
//    IDLE: on a low sample at a tick, go to START.
//    START: after OVERSAMPLE/2-1 more ticks (bit centre), resample. If the line is high it was a glitch:
//    return to IDLE with no output.
//    DATA: sample every OVERSAMPLE ticks, LSB first.
//    STOP: sample at the centre. High -> byte complete. Low -> pulse rx_frame_err, discard the byte,
//    go to RESYNC; RESYNC waits for a high sample, then returns to IDLE.
//  - Output buffer (1 entry): on completion with rx_valid=0, load rx_data and set rx_valid the next cycle.
//    rx_valid clears on rx_valid&&rx_ready.
//  - Completion while rx_valid=1 and rx_ready=0: pulse rx_overrun; the new byte is dropped and the
//    old byte is kept. If rx_ready=1 in the same cycle as completion, the buffer takes the new byte
//    with no overrun.
//  - Reset mid-frame: both FSMs go to IDLE immediately. A frame in flight is abandoned and the TX line
//    returns high.
// CONFIGURATION
//  UART_PARITY_EN defined: format is 8E1.
//   - TX inserts an even-parity bit (XOR of the data bits) before STOP.
//   - RX checks the parity bit. On mismatch it pulses rx_parity_err in the completion cycle and still
//     delivers the byte.
//   - Frame length is 11 bits.
//  Undefined: 8N1, no PARITY state, rx_parity_err tied to 0, frame length is 10 bits.
// TESTING (CLK_HZ=1600000, BAUD=100000, OVERSAMPLE=16 -> DIV=1, 16 clocks per bit)
//  1. Send tx 0xA5 -> line: low 16 clk, then 1,0,1,0,0,1,0,1 at 16 clk each, then high;
//     tx_ready is high again 160 clk after start.
//  2. Loop loan_io_out[50] back to loan_io_in[49] and send 0x3C -> rx_valid with rx_data=0x3C,
//     rx_frame_err=0.
//  3. Drive an RX low glitch of 4 clk -> no rx_valid, FSM back to IDLE, the next good byte 0x81
//     is received.
//  4. Send frame 0x55 with a low stop bit -> rx_frame_err pulses once, rx_valid stays 0;
//     after the line goes high, 0x12 is received.
//  5. Hold rx_ready=0 and receive 0x11 then 0x22 -> rx_overrun pulses once, rx_data stays 0x11.
//  6. Assert reset_reset mid-TX-byte -> line goes high and tx_ready=1 immediately;
//     with UART_PARITY_EN, RX 0x07 with wrong parity -> rx_parity_err=1 and rx_data=0x07.

Source files
------------

// File: rtl/uart_loanio_xcvr.sv
`default_nettype none
// ============================================================================
//  Module   : uart_loanio_xcvr
//  Purpose  : Fabric UART transceiver on the HPS loan-IO bus. TX drives
//             loan_io_out[TX_PIN], RX reads loan_io_in[RX_PIN]. 8N1 format,
//             LSB first, idle-high line. Byte streams use valid/ready.
//  Config   : define UART_PARITY_EN for 8E1 (even parity bit before STOP,
//             rx_parity_err reports mismatches). Undefined: 8N1.
//  Ports    : clk_clk / reset_reset (async, active-high)
//             tx_data, tx_valid -> tx_ready       transmit byte stream
//             rx_data, rx_valid <- rx_ready       receive byte stream
//             rx_frame_err, rx_overrun, rx_parity_err   1-cycle pulses
//             loan_io_in / loan_io_out / loan_io_oe     67-bit loan-IO bus
//  Revision : 1.0 - initial release
// ============================================================================
module uart_loanio_xcvr #(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int RX_PIN     = 49,
   parameter int TX_PIN     = 50
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        rx_frame_err,
   output logic        rx_overrun,
   output logic        rx_parity_err,
   input  logic [66:0] loan_io_in,
   output logic [66:0] loan_io_out,
   output logic [66:0] loan_io_oe
);

   // Rounded clock divider for the oversample tick, never below 1.
   localparam int TICK_HZ = BAUD * OVERSAMPLE;
   localparam int DIV_RAW = (CLK_HZ + TICK_HZ / 2) / TICK_HZ;
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DCW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OCW     = $clog2(OVERSAMPLE);
   localparam logic [OCW-1:0] LAST_TICK  = OCW'(OVERSAMPLE - 1);
   // START entry happens on the detecting tick; centre is OVERSAMPLE/2-1 ticks later.
   localparam logic [OCW-1:0] START_LAST = OCW'(OVERSAMPLE / 2 - 2);

   // ---------------------------------------------------------------- tick
   logic [DCW-1:0] div_cnt_q;
   logic           tick;

   assign tick = (div_cnt_q == DCW'(DIV - 1));

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         div_cnt_q <= '0;
      end else if (tick) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_q + DCW'(1);
      end
   end

   // ---------------------------------------------------------------- TX
   typedef enum logic [2:0] {
      TX_IDLE,
      TX_WAIT,
      TX_START,
      TX_DATA,
`ifdef UART_PARITY_EN
      TX_PAR,
`endif
      TX_STOP
   } tx_state_t;

   tx_state_t      tx_state_q;
   logic           tx_ready_q;
   logic           tx_line_q;
   logic [7:0]     tx_shift_q;
   logic [OCW-1:0] tx_tick_q;
   logic [2:0]     tx_bit_q;
   logic           tx_bit_end;
`ifdef UART_PARITY_EN
   logic           tx_par_q;
`endif

   assign tx_bit_end = tick && (tx_tick_q == LAST_TICK);

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         tx_state_q <= TX_IDLE;
         tx_ready_q <= 1'b1;
         tx_line_q  <= 1'b1;
         tx_shift_q <= '0;
         tx_tick_q  <= '0;
         tx_bit_q   <= '0;
`ifdef UART_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         // Bit-time counter runs on every tick; state transitions reset it.
         if (tick) begin
            tx_tick_q <= (tx_tick_q == LAST_TICK) ? '0 : tx_tick_q + OCW'(1);
         end
         case (tx_state_q)
            TX_IDLE: begin
               if (tx_valid && tx_ready_q) begin
                  tx_shift_q <= tx_data;
`ifdef UART_PARITY_EN
                  tx_par_q   <= ^tx_data;
`endif
                  tx_ready_q <= 1'b0;
                  tx_state_q <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               // Align the start bit with the shared tick grid.
               if (tick) begin
                  tx_line_q  <= 1'b0;
                  tx_tick_q  <= '0;
                  tx_state_q <= TX_START;
               end
            end
            TX_START: begin
               if (tx_bit_end) begin
                  tx_line_q  <= tx_shift_q[0];
                  tx_bit_q   <= '0;
                  tx_state_q <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                     tx_line_q  <= tx_par_q;
                     tx_state_q <= TX_PAR;
`else
                     tx_line_q  <= 1'b1;
                     tx_state_q <= TX_STOP;
`endif
                  end else begin
                     tx_shift_q <= tx_shift_q >> 1;
                     tx_line_q  <= tx_shift_q[1];
                     tx_bit_q   <= tx_bit_q + 3'd1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            TX_PAR: begin
               if (tx_bit_end) begin
                  tx_line_q  <= 1'b1;
                  tx_state_q <= TX_STOP;
               end
            end
`endif
            TX_STOP: begin
               if (tx_bit_end) begin
                  tx_ready_q <= 1'b1;
                  tx_state_q <= TX_IDLE;
               end
            end
            default: begin
               tx_line_q  <= 1'b1;
               tx_ready_q <= 1'b1;
               tx_state_q <= TX_IDLE;
            end
         endcase
      end
   end

   assign tx_ready = tx_ready_q;

   // ---------------------------------------------------------------- RX
   logic rx_meta_q;
   logic rx_sync_q;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= loan_io_in[RX_PIN];
         rx_sync_q <= rx_meta_q;
      end
   end

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_PARITY_EN
      RX_PAR,
`endif
      RX_STOP,
      RX_RESYNC
   } rx_state_t;

   rx_state_t      rx_state_q;
   logic [OCW-1:0] rx_tick_q;
   logic [2:0]     rx_bit_q;
   logic [7:0]     rx_shift_q;
   logic [7:0]     rx_data_q;
   logic           rx_valid_q;
   logic           rx_frame_err_q;
   logic           rx_overrun_q;
   logic           rx_sample;
`ifdef UART_PARITY_EN
   logic           rx_par_q;
   logic           rx_parity_err_q;
`endif

   assign rx_sample = tick && (rx_tick_q == LAST_TICK);

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         rx_state_q      <= RX_IDLE;
         rx_tick_q       <= '0;
         rx_bit_q        <= '0;
         rx_shift_q      <= '0;
         rx_data_q       <= '0;
         rx_valid_q      <= 1'b0;
         rx_frame_err_q  <= 1'b0;
         rx_overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_q        <= 1'b0;
         rx_parity_err_q <= 1'b0;
`endif
      end else begin
         rx_frame_err_q <= 1'b0;
         rx_overrun_q   <= 1'b0;
`ifdef UART_PARITY_EN
         rx_parity_err_q <= 1'b0;
`endif
         if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end
         if (tick) begin
            rx_tick_q <= (rx_tick_q == LAST_TICK) ? '0 : rx_tick_q + OCW'(1);
         end
         case (rx_state_q)
            RX_IDLE: begin
               if (tick && !rx_sync_q) begin
                  rx_tick_q  <= '0;
                  rx_state_q <= RX_START;
               end
            end
            RX_START: begin
               if (tick && (rx_tick_q == START_LAST)) begin
                  rx_tick_q  <= '0;
                  rx_bit_q   <= '0;
                  // High at the centre means the falling edge was a glitch.
                  rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
               end
            end
            RX_DATA: begin
               if (rx_sample) begin
                  rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                     rx_state_q <= RX_PAR;
`else
                     rx_state_q <= RX_STOP;
`endif
                  end else begin
                     rx_bit_q <= rx_bit_q + 3'd1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            RX_PAR: begin
               if (rx_sample) begin
                  rx_par_q   <= rx_sync_q;
                  rx_state_q <= RX_STOP;
               end
            end
`endif
            RX_STOP: begin
               if (rx_sample) begin
                  if (rx_sync_q) begin
                     // A consumer taking the old byte this cycle frees the slot.
                     if (!rx_valid_q || rx_ready) begin
                        rx_data_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                     end else begin
                        rx_overrun_q <= 1'b1;
                     end
`ifdef UART_PARITY_EN
                     rx_parity_err_q <= (^rx_shift_q) != rx_par_q;
`endif
                     rx_state_q <= RX_IDLE;
                  end else begin
                     rx_frame_err_q <= 1'b1;
                     rx_state_q     <= RX_RESYNC;
                  end
               end
            end
            RX_RESYNC: begin
               if (tick && rx_sync_q) begin
                  rx_state_q <= RX_IDLE;
               end
            end
            default: begin
               rx_state_q <= RX_IDLE;
            end
         endcase
      end
   end

   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign rx_frame_err = rx_frame_err_q;
   assign rx_overrun   = rx_overrun_q;
`ifdef UART_PARITY_EN
   assign rx_parity_err = rx_parity_err_q;
`else
   assign rx_parity_err = 1'b0;
`endif

   // ---------------------------------------------------------------- loan IO
   always_comb begin
      loan_io_out         = '0;
      loan_io_out[TX_PIN] = tx_line_q;
   end

   always_comb begin
      loan_io_oe         = '0;
      loan_io_oe[TX_PIN] = 1'b1;
   end

   // Only RX_PIN is consumed; the rest of the bus is intentionally ignored.
   logic unused_loan_in;
   assign unused_loan_in = ^loan_io_in;

endmodule
`default_nettype wire

// File: tb/tb_uart_loanio_xcvr.sv
`timescale 1ns/1ps
module tb_uart_loanio_xcvr;

   localparam int CLK_HZ = 1600000;
   localparam int BAUD   = 100000;
   localparam int OVS    = 16;
   localparam int RXP    = 49;
   localparam int TXP    = 50;
   localparam int BITCLK = 16;          // DIV=1 -> 16 clocks per bit
`ifdef UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  tx_data = '0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic        rx_frame_err, rx_overrun, rx_parity_err;
   logic [66:0] io_in, io_out, io_oe;
   logic [66:0] io_bg = '0;
   logic        loop_en = 1'b0;
   logic        rx_drive = 1'b1;
   logic [66:0] pin_mask;

   int checks = 0;
   int failures = 0;
   int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;

   always #5 clk = ~clk;

   always_comb begin
      io_in      = io_bg;
      io_in[RXP] = loop_en ? io_out[TXP] : rx_drive;
   end

   always @(negedge clk) begin
      if (rx_frame_err)  ferr_cnt++;
      if (rx_overrun)    ovr_cnt++;
      if (rx_parity_err) perr_cnt++;
   end

   uart_loanio_xcvr #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVS), .RX_PIN(RXP), .TX_PIN(TXP)
   ) dut (
      .clk_clk(clk), .reset_reset(rst),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_parity_err(rx_parity_err),
      .loan_io_in(io_in), .loan_io_out(io_out), .loan_io_oe(io_oe)
   );

   task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line levels of one frame, index 0 = start bit.
   function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b, input logic bad_par,
                                                   input logic stop);
      logic [NBITS-1:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_PARITY_EN
      f[9] = (^b) ^ bad_par;
`else
      if (bad_par) f[0] = 1'b0;
`endif
      f[NBITS-1] = stop;
      return f;
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Send one byte and check the line waveform and tx_ready timing.
   task automatic tx_send(input logic [7:0] b);
      logic [NBITS-1:0] exp;
      bit found;
      exp = frame_bits(b, 1'b0, 1'b1);
      @(negedge clk);
      check("tx_ready_idle", tx_ready, 1'b1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (io_out[TXP] == 1'b0) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("tx_start_seen", found, 1'b1);
      if (!found) return;
      for (int k = 1; k <= NBITS * BITCLK; k++) begin
         @(negedge clk);
         if (k % BITCLK == BITCLK / 2)
            check($sformatf("tx_bit%0d_of_%02h", k / BITCLK, b), io_out[TXP], exp[k / BITCLK]);
         if (k == NBITS * BITCLK - 1) check("tx_ready_busy", tx_ready, 1'b0);
         if (k == NBITS * BITCLK)     check("tx_ready_back", tx_ready, 1'b1);
      end
   endtask

   // Drive one frame on the RX pin, then idle high for two bit times.
   task automatic rx_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      logic [NBITS-1:0] f;
      f = frame_bits(b, bad_par, stop);
      for (int i = 0; i < NBITS; i++) begin
         rx_drive = f[i];
         repeat (BITCLK) @(negedge clk);
      end
      rx_drive = 1'b1;
      repeat (2 * BITCLK) @(negedge clk);
      #1;
   endtask

   task automatic rx_consume();
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      #1;
      check("rx_valid_cleared", rx_valid, 1'b0);
   endtask

   task automatic rx_expect(input logic [7:0] b);
      check("rx_valid_set", rx_valid, 1'b1);
      check($sformatf("rx_data_%02h", b), rx_data, b);
   endtask

   initial begin
      #2ms;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b;
      int f0, o0, p0;
      pin_mask      = '0;
      pin_mask[TXP] = 1'b1;
      io_bg         = {35'($urandom), 32'($urandom)};

      // Reset values
      step(3);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_frame_err", rx_frame_err, 1'b0);
      check("rst_overrun", rx_overrun, 1'b0);
      check("rst_parity_err", rx_parity_err, 1'b0);
      check("rst_loan_out", io_out, pin_mask);
      check("rst_loan_oe", io_oe, pin_mask);
      @(negedge clk);
      rst = 1'b0;
      step(2);

      // TX waveform: directed byte then random bytes
      tx_send(8'hA5);
      for (int i = 0; i < 3; i++) tx_send(8'($urandom));
      check("loan_oe_const", io_oe, pin_mask);

      // Loopback TX -> RX
      loop_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b = (i == 0) ? 8'h3C : 8'($urandom);
         f0 = ferr_cnt;
         tx_send(b);
         step(4);
         rx_expect(b);
         check("loop_no_frame_err", ferr_cnt - f0, 0);
         rx_consume();
      end
      loop_en = 1'b0;
      step(2 * BITCLK);

      // Short low glitch must be ignored
      f0 = ferr_cnt;
      @(negedge clk);
      rx_drive = 1'b0;
      repeat (4) @(negedge clk);
      rx_drive = 1'b1;
      step(3 * BITCLK);
      check("glitch_no_valid", rx_valid, 1'b0);
      check("glitch_no_frame_err", ferr_cnt - f0, 0);
      rx_frame(8'h81, 1'b0, 1'b1);
      rx_expect(8'h81);
      rx_consume();

      // Low stop bit -> framing error, byte discarded, recovery
      f0 = ferr_cnt;
      rx_frame(8'h55, 1'b0, 1'b0);
      check("frame_err_once", ferr_cnt - f0, 1);
      check("frame_err_no_valid", rx_valid, 1'b0);
      rx_frame(8'h12, 1'b0, 1'b1);
      rx_expect(8'h12);
      rx_consume();

      // Overrun: second byte dropped, first kept
      o0 = ovr_cnt;
      rx_frame(8'h11, 1'b0, 1'b1);
      rx_frame(8'h22, 1'b0, 1'b1);
      check("overrun_once", ovr_cnt - o0, 1);
      rx_expect(8'h11);
      rx_consume();

      // Random received bytes with the buffer drained between frames
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         rx_frame(b, 1'b0, 1'b1);
         rx_expect(b);
         rx_consume();
      end

`ifdef UART_PARITY_EN
      p0 = perr_cnt;
      rx_frame(8'h07, 1'b1, 1'b1);
      check("parity_err_once", perr_cnt - p0, 1);
      rx_expect(8'h07);
      rx_consume();
      check("parity_err_total", perr_cnt, 1);
`else
      p0 = 0;
      check("parity_err_total", perr_cnt, p0);
`endif

      // Reset in the middle of a transmitted byte
      @(negedge clk);
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (3 * BITCLK) @(negedge clk);
      #1;
      check("pre_reset_line_low", io_out[TXP], 1'b0);
      check("pre_reset_busy", tx_ready, 1'b0);
      rst = 1'b1;
      #1;
      check("reset_line_high", io_out[TXP], 1'b1);
      check("reset_tx_ready", tx_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      step(2);
      check("reset_line_stays_high", io_out[TXP], 1'b1);
      tx_send(8'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
